shrsi_shared_arbiter: RTL and testbench

//  Shares one arithmetic right-shift datapath (signed lhs >>> rhs) between NUM_REQ

---
 rtl/shrsi_shared_arbiter_pkg.sv | 26 ++
 rtl/shrsi_shared_arbiter_rr_arbiter.sv | 37 +++
 rtl/shrsi_shared_arbiter.sv | 109 ++++++++++
 tb/tb_shrsi_shared_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/shrsi_shared_arbiter_pkg.sv
// Shared definitions for the shared arithmetic-right-shift unit and its arbiter.
// Provides pointer-width helpers so other shared units size their round-robin pointers the same way.
package shrsi_shared_arbiter_pkg;

  // Number of bits needed to index 'value' distinct items (0 for value <= 1).
  function automatic int clog2(input int value);
    int bits;
    int remaining;
    bits = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      bits++;
      remaining = remaining >> 1;
    end
    return bits;
  endfunction

  // Round-robin pointer width; never narrower than one bit.
  function automatic int rr_width(input int num_req);
    return (num_req > 1) ? clog2(num_req) : 1;
  endfunction

  localparam int DEFAULT_DATA_TYPE = 32;
  localparam int DEFAULT_NUM_REQ   = 2;

endpackage

// File: rtl/shrsi_shared_arbiter_rr_arbiter.sv
// Purely combinational round-robin arbiter: grants the first requester at or after ptr, wrapping.
// Kept free of state so any shared unit can own its pointer register.
module rr_arbiter
  import shrsi_shared_arbiter_pkg::*;
#(
  parameter int N = DEFAULT_NUM_REQ,
  parameter int W = rr_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         any_grant
);

  // Two passes: indices from ptr upward first, then the wrapped-around indices below ptr.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any_grant && req[i] && (i >= int'(ptr))) begin
        grant[i]  = 1'b1;
        grant_idx = W'(i);
        any_grant = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any_grant && req[i] && (i < int'(ptr))) begin
        grant[i]  = 1'b1;
        grant_idx = W'(i);
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shrsi_shared_arbiter.sv
// One signed arithmetic right shifter shared round-robin between NUM_REQ join-style requesters,
// each with its own registered result slot.
module shrsi_shared_arbiter
  import shrsi_shared_arbiter_pkg::*;
#(
  parameter int DATA_TYPE = DEFAULT_DATA_TYPE,
  parameter int NUM_REQ   = DEFAULT_NUM_REQ
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ*DATA_TYPE-1:0]   lhs,
  input  logic [NUM_REQ-1:0]             lhs_valid,
  output logic [NUM_REQ-1:0]             lhs_ready,
  input  logic [NUM_REQ*DATA_TYPE-1:0]   rhs,
  input  logic [NUM_REQ-1:0]             rhs_valid,
  output logic [NUM_REQ-1:0]             rhs_ready,
  output logic [NUM_REQ*DATA_TYPE-1:0]   result,
  output logic [NUM_REQ-1:0]             result_valid,
  input  logic [NUM_REQ-1:0]             result_ready
);

  localparam int RR_W = rr_width(NUM_REQ);

  logic [RR_W-1:0]                     ptr;
  logic [RR_W-1:0]                     ptr_next;
  logic [NUM_REQ-1:0]                  slot_free;
  logic [NUM_REQ-1:0]                  eligible;
  logic [NUM_REQ-1:0]                  grant;
  logic [RR_W-1:0]                     grant_idx;
  logic                                any_grant;
  logic [DATA_TYPE-1:0]                lhs_g;
  logic [DATA_TYPE-1:0]                rhs_g;
  logic [DATA_TYPE-1:0]                res;
  logic [NUM_REQ-1:0][DATA_TYPE-1:0]   slot_data;

  // A full slot that is draining this cycle can be refilled in the same cycle.
  // Gating with rst keeps every ready low while reset is held.
  assign slot_free = ~result_valid | result_ready;
  assign eligible  = lhs_valid & rhs_valid & slot_free & {NUM_REQ{rst}};

  rr_arbiter #(
    .N (NUM_REQ),
    .W (RR_W)
  ) u_rr_arbiter (
    .req       (eligible),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign lhs_ready = grant;
  assign rhs_ready = grant;

  always_comb begin
    if (grant_idx == RR_W'(NUM_REQ - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (any_grant) begin
      ptr <= ptr_next;
    end
  end

  always_comb begin
    lhs_g = '0;
    rhs_g = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        lhs_g = lhs[i*DATA_TYPE +: DATA_TYPE];
        rhs_g = rhs[i*DATA_TYPE +: DATA_TYPE];
      end
    end
  end

  // Shift amounts at or beyond the width saturate to a full sign fill.
  always_comb begin
    if (rhs_g >= DATA_TYPE'(DATA_TYPE)) begin
      res = {DATA_TYPE{lhs_g[DATA_TYPE-1]}};
    end else begin
      res = $signed(lhs_g) >>> rhs_g;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_data    <= '0;
      result_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          slot_data[i]    <= res;
          result_valid[i] <= 1'b1;
        end else if (result_ready[i]) begin
          result_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign result = slot_data;

endmodule

// File: tb/tb_shrsi_shared_arbiter.sv
// Directed self-checking bench for shrsi_shared_arbiter with DATA_TYPE=32, NUM_REQ=2.
module tb_shrsi_shared_arbiter;

  logic        clk;
  logic        rst;
  logic [63:0] lhs;
  logic [1:0]  lhs_valid;
  logic [1:0]  lhs_ready;
  logic [63:0] rhs;
  logic [1:0]  rhs_valid;
  logic [1:0]  rhs_ready;
  logic [63:0] result;
  logic [1:0]  result_valid;
  logic [1:0]  result_ready;

  int tests_run;
  int tests_failed;

  shrsi_shared_arbiter #(
    .DATA_TYPE (32),
    .NUM_REQ   (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .lhs          (lhs),
    .lhs_valid    (lhs_valid),
    .lhs_ready    (lhs_ready),
    .rhs          (rhs),
    .rhs_valid    (rhs_valid),
    .rhs_ready    (rhs_ready),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] lv, input logic [1:0] rv,
                               input logic [31:0] l0, input logic [31:0] r0,
                               input logic [31:0] l1, input logic [31:0] r1,
                               input logic [1:0] rr);
    lhs_valid    = lv;
    rhs_valid    = rv;
    lhs          = {l1, l0};
    rhs          = {r1, r0};
    result_ready = rr;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vec_lhs [4];
  logic [31:0] vec_rhs [4];
  logic [31:0] vec_exp [4];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    vec_lhs[0] = 32'h8000_0000; vec_rhs[0] = 32'd4;  vec_exp[0] = 32'hF800_0000;
    vec_lhs[1] = 32'h7FFF_FFFF; vec_rhs[1] = 32'd31; vec_exp[1] = 32'h0000_0000;
    vec_lhs[2] = 32'hFFFF_FFF0; vec_rhs[2] = 32'd40; vec_exp[2] = 32'hFFFF_FFFF;
    vec_lhs[3] = 32'h1234_5678; vec_rhs[3] = 32'd0;  vec_exp[3] = 32'h1234_5678;

    // Reset held with every valid high
    rst = 1'b0;
    applyStimulus(2'b11, 2'b11, 32'h8000_0000, 32'd4, 32'h7FFF_FFFF, 32'd31, 2'b11);
    repeat (2) stepClock();
    checkOutput("reset_lhs_ready", 64'(lhs_ready), 64'h0);
    checkOutput("reset_rhs_ready", 64'(rhs_ready), 64'h0);
    checkOutput("reset_result_valid", 64'(result_valid), 64'h0);
    checkOutput("reset_result", result, 64'h0);
    rst = 1'b1;
    #1;
    checkOutput("first_grant_req0", 64'(lhs_ready), 64'h1);
    stepClock();
    checkOutput("first_result_valid", 64'(result_valid), 64'h1);
    checkOutput("first_result0", 64'(result[31:0]), 64'hF800_0000);
    checkOutput("after_first_ptr1", 64'(lhs_ready), 64'h2);

    // Single requester, back-to-back sign/overflow vectors
    for (int v = 0; v < 4; v++) begin
      applyStimulus(2'b01, 2'b01, vec_lhs[v], vec_rhs[v], 32'h0, 32'h0, 2'b11);
      #1;
      checkOutput($sformatf("single_lhs_ready_%0d", v), 64'(lhs_ready), 64'h1);
      checkOutput($sformatf("single_rhs_ready_%0d", v), 64'(rhs_ready), 64'h1);
      stepClock();
      checkOutput($sformatf("single_result_%0d", v), 64'(result[31:0]), 64'(vec_exp[v]));
      checkOutput($sformatf("single_valid_%0d", v), 64'(result_valid), 64'h1);
    end

    // Reset right after the grant to req0 (which left the pointer at 1)
    rst = 1'b0;
    #1;
    checkOutput("midreset_result_valid", 64'(result_valid), 64'h0);
    checkOutput("midreset_result", result, 64'h0);
    checkOutput("midreset_ready", 64'(lhs_ready), 64'h0);
    stepClock();
    rst = 1'b1;
    applyStimulus(2'b11, 2'b11, 32'h0, 32'd0, 32'h0, 32'd0, 2'b11);
    #1;
    checkOutput("midreset_ptr_zero", 64'(lhs_ready), 64'h1);

    // Fairness: grants alternate 0,1,0,1,0,1
    for (int c = 0; c < 6; c++) begin
      logic [1:0] exp_grant;
      exp_grant = (c % 2 == 0) ? 2'b01 : 2'b10;
      applyStimulus(2'b11, 2'b11, 32'(c * 16), 32'd2, 32'(c << 8), 32'd8, 2'b11);
      #1;
      checkOutput($sformatf("fair_grant_%0d", c), 64'(lhs_ready), 64'(exp_grant));
      stepClock();
      checkOutput($sformatf("fair_valid_%0d", c), 64'(result_valid), 64'(exp_grant));
      if (c % 2 == 0) begin
        checkOutput($sformatf("fair_result0_%0d", c), 64'(result[31:0]), 64'(c * 4));
      end else begin
        checkOutput($sformatf("fair_result1_%0d", c), 64'(result[63:32]), 64'(c));
      end
    end

    // Backpressure: fill slot0, then hold result_ready[0] low
    applyStimulus(2'b11, 2'b11, 32'hAAAA_0000, 32'd16, 32'h0, 32'd4, 2'b10);
    #1;
    checkOutput("bp_fill_grant", 64'(lhs_ready), 64'h1);
    stepClock();
    checkOutput("bp_fill_result0", 64'(result[31:0]), 64'hFFFF_AAAA);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(2'b11, 2'b11, 32'h0000_1234, 32'd0, 32'(k << 4), 32'd4, 2'b10);
      #1;
      checkOutput($sformatf("bp_grant_%0d", k), 64'(lhs_ready), 64'h2);
      stepClock();
      checkOutput($sformatf("bp_slot0_stable_%0d", k), 64'(result[31:0]), 64'hFFFF_AAAA);
      checkOutput($sformatf("bp_valid_%0d", k), 64'(result_valid), 64'h3);
      checkOutput($sformatf("bp_result1_%0d", k), 64'(result[63:32]), 64'(k));
    end
    applyStimulus(2'b11, 2'b11, 32'h0000_1234, 32'd0, 32'h0, 32'd4, 2'b11);
    #1;
    checkOutput("bp_release_grant", 64'(lhs_ready), 64'h1);
    stepClock();
    checkOutput("bp_release_result0", 64'(result[31:0]), 64'h0000_1234);

    // Partial operands on req1: lhs only, then rhs arrives
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b10, 2'b00, 32'h0, 32'd0, 32'hFFFF_FF00, 32'd4, 2'b11);
      #1;
      checkOutput($sformatf("partial_lhs_ready_%0d", k), 64'(lhs_ready), 64'h0);
      checkOutput($sformatf("partial_rhs_ready_%0d", k), 64'(rhs_ready), 64'h0);
      stepClock();
    end
    applyStimulus(2'b10, 2'b10, 32'h0, 32'd0, 32'hFFFF_FF00, 32'd4, 2'b11);
    #1;
    checkOutput("partial_join_grant", 64'(lhs_ready), 64'h2);
    stepClock();
    checkOutput("partial_result1", 64'(result[63:32]), 64'hFFFF_FFF0);
    checkOutput("partial_valid", 64'(result_valid), 64'h2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
